// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: two-flop input synchroniser, mid-bit start
// validation, bit-centre sampling and a one-entry valid/ready holding register.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_HIGH | line must be seen high before arming (after reset or break)
// IDLE      | armed, waiting for a falling edge on the synchronised line
// START     | counting to the start-bit centre, then re-checking the line
// DATA      | sampling eight data bits at their centres, LSB first
// STOP      | sampling the stop bit; deliver the byte or flag a framing error

module uart_rx_ctrl #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       fpga_clk_i,
    input  logic       rst_n_i,
    input  logic       uart_rxd_i,
    input  logic       rx_ready_i,
    input  logic       clr_err_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int H   = CPB / 2;
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    logic [1:0]    sync_q;
    logic          rxd_s;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          busy_q;
    logic          frame_err_q;

    logic          deliver;

    logic [7:0]    rx_data_q,  rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q,  overrun_d;

    // Both flops reset high so the line reads idle straight out of reset.
    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd_i};
        end
    end

    assign rxd_s = sync_q[1];

    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= WAIT_HIGH;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (!rxd_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q != CNT_HALF) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else if (!rxd_s) begin
                        state_q   <= DATA;
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt_q != CNT_BIT) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        shift_q <= {rxd_s, shift_q[7:1]};
                        cnt_q   <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leaving at the stop-bit centre re-arms half a bit early,
                    // so a start bit that follows with no gap is still caught.
                    if (cnt_q != CNT_BIT) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        busy_q <= 1'b0;
                        if (rxd_s) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_HIGH;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign deliver = (state_q == STOP) && (cnt_q == CNT_BIT) && rxd_s;

    // A delivery into a full register only lands if the old byte leaves on
    // the same edge; otherwise the new byte is dropped and the loss recorded.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
        if (clr_err_i) begin
            overrun_d = 1'b0;
        end
        if (deliver) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at CPB=10: directed scenarios plus randomized
// frames checked against a frame-level model of the holding register.

module tb_uart_rx_ctrl;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int H      = CPB / 2;
    localparam int LAT    = 2 + H + 9 * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rxd     = 1'b1;
    logic       ready   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .fpga_clk_i (clk),
        .rst_n_i    (rst_n),
        .uart_rxd_i (rxd),
        .rx_ready_i (ready),
        .clr_err_i  (clr_err),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    // Called just after a negedge: the start bit is captured at the next edge.
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rxd = b[i];
        end
        repeat (CPB) @(negedge clk);
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rxd = 1'b1; ready = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0", busy, rx_valid); end
    endtask

    task automatic test_single;
        int k;
        ready = 1'b1;
        @(negedge clk); k = cyc + 1;
        fork
            drive_frame(8'hA5, 1'b1);
            begin
                while (cyc < k + LAT + 3) begin
                    @(negedge clk);
                    checks++;
                    if (rx_valid !== (cyc == k + LAT)) begin errors++; $display("FAIL single_valid @%0d: got %b want %b", cyc - k, rx_valid, cyc == k + LAT); end
                    if (cyc == k + LAT) begin
                        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rx_data); end
                    end
                    checks++;
                    if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL single_errs @%0d: fe=%b ov=%b want 0 0", cyc - k, frame_err, overrun); end
                end
            end
        join
    endtask

    task automatic test_glitch;
        int k;
        ready = 1'b1;
        @(negedge clk); k = cyc + 1;
        rxd = 1'b0;
        fork
            begin repeat (3) @(negedge clk); rxd = 1'b1; end
            begin
                while (cyc < k + 40) begin
                    @(negedge clk);
                    if (cyc == k + 4) begin
                        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
                    end
                    if (cyc == k + 8) begin
                        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
                    end
                    checks++;
                    if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL glitch_quiet @%0d: valid=%b fe=%b want 0 0", cyc - k, rx_valid, frame_err); end
                end
            end
        join
        @(negedge clk); k = cyc + 1;
        fork
            drive_frame(8'h3C, 1'b1);
            begin
                while (cyc < k + LAT) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL glitch_follow: valid=%b data=%h want 1 3c", rx_valid, rx_data); end
            end
        join
    endtask

    task automatic test_break;
        int k;
        int fe_count;
        ready = 1'b1; fe_count = 0;
        @(negedge clk); k = cyc + 1;
        rxd = 1'b0;
        fork
            begin repeat (20 * CPB) @(negedge clk); rxd = 1'b1; end
            begin
                while (cyc < k + 20 * CPB + 5) begin
                    @(negedge clk);
                    if (frame_err === 1'b1) fe_count++;
                    checks++;
                    if (frame_err !== (cyc == k + LAT)) begin errors++; $display("FAIL break_frame_err @%0d: got %b want %b", cyc - k, frame_err, cyc == k + LAT); end
                    checks++;
                    if (rx_valid !== 1'b0) begin errors++; $display("FAIL break_valid @%0d: got %b want 0", cyc - k, rx_valid); end
                    if (cyc == k + 150) begin
                        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_rearmed: busy=%b want 0", busy); end
                    end
                end
            end
        join
        checks++; if (fe_count != 1) begin errors++; $display("FAIL break_fe_pulses: got %0d want 1", fe_count); end
        repeat (5) @(negedge clk);
        k = cyc + 1;
        fork
            drive_frame(8'h0F, 1'b1);
            begin
                while (cyc < k + LAT) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h0F) begin errors++; $display("FAIL break_follow: valid=%b data=%h want 1 0f", rx_valid, rx_data); end
            end
        join
    endtask

    task automatic test_overrun;
        int k;
        ready = 1'b0;
        @(negedge clk); k = cyc + 1;
        fork
            drive_frame(8'h11, 1'b1);
            begin
                while (cyc < k + LAT) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first: valid=%b data=%h want 1 11", rx_valid, rx_data); end
            end
        join
        k = cyc + 1;
        fork
            drive_frame(8'h22, 1'b1);
            begin
                while (cyc < k + LAT - 1) @(negedge clk);
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", overrun); end
                @(negedge clk);
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_keep: valid=%b data=%h want 1 11", rx_valid, rx_data); end
            end
        join
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_hold: valid=%b data=%h want 1 11", rx_valid, rx_data); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: valid=%b want 0", rx_valid); end
    endtask

    task automatic test_coincident;
        int k;
        ready = 1'b0;
        @(negedge clk); k = cyc + 1;
        fork
            drive_frame(8'h33, 1'b1);
            begin
                while (cyc < k + LAT) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin errors++; $display("FAIL coin_first: valid=%b data=%h want 1 33", rx_valid, rx_data); end
            end
        join
        k = cyc + 1;
        fork
            drive_frame(8'h44, 1'b1);
            begin
                while (cyc < k + LAT - 1) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin errors++; $display("FAIL coin_before: valid=%b data=%h want 1 33", rx_valid, rx_data); end
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h44) begin errors++; $display("FAIL coin_load: valid=%b data=%h want 1 44", rx_valid, rx_data); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coin_overrun: got %b want 0", overrun); end
                @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h44) begin errors++; $display("FAIL coin_hold: valid=%b data=%h want 1 44", rx_valid, rx_data); end
            end
        join
        ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL coin_drain: valid=%b want 0", rx_valid); end
    endtask

    // Model: each frame yields (byte, due edge); the holding register follows
    // the load/overrun/handshake rules edge by edge with the driven ready.
    task automatic test_random_frames;
        logic [7:0] bytes[$];
        int         dues[$];
        logic       mv, mo, r, done;
        logic [7:0] md, dv;
        logic [7:0] b;
        int         dd, gap, bias, guard;
        mv = 1'b0; mo = 1'b0; md = 8'h00; done = 1'b0; bias = 50; guard = 0;
        ready = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    b   = 8'($urandom);
                    gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
                    repeat (gap) @(negedge clk);
                    bytes.push_back(b);
                    dues.push_back(cyc + 1 + LAT);
                    drive_frame(b, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (guard < 5000) begin
                    @(negedge clk);
                    guard++;
                    r = ready;
                    if (dues.size() > 0 && dues[0] == cyc) begin
                        dv = bytes.pop_front();
                        dd = dues.pop_front();
                        if (!mv || r) begin md = dv; mv = 1'b1; end
                        else mo = 1'b1;
                    end else if (mv && r) begin
                        mv = 1'b0;
                    end
                    checks++;
                    if (rx_valid !== mv) begin errors++; $display("FAIL rand_valid @%0d: got %b want %b", cyc, rx_valid, mv); end
                    if (mv) begin
                        checks++; if (rx_data !== md) begin errors++; $display("FAIL rand_data @%0d: got %h want %h", cyc, rx_data, md); end
                    end
                    checks++;
                    if (overrun !== mo) begin errors++; $display("FAIL rand_overrun @%0d: got %b want %b", cyc, overrun, mo); end
                    checks++;
                    if (frame_err !== 1'b0) begin errors++; $display("FAIL rand_frame_err @%0d: got %b want 0", cyc, frame_err); end
                    if ($urandom_range(0, 149) == 0) begin
                        case ($urandom_range(0, 3))
                            0:       bias = 0;
                            1:       bias = 10;
                            2:       bias = 60;
                            default: bias = 100;
                        endcase
                    end
                    ready = ($urandom_range(0, 99) < bias);
                    if (done && dues.size() == 0) break;
                end
            end
        join
        checks++; if (guard >= 5000) begin errors++; $display("FAIL rand_timeout: cycles=%0d limit 5000", guard); end
        ready = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_mid_reset;
        int k;
        logic [7:0] b;
        b = 8'h5A; ready = 1'b1;
        @(negedge clk); k = cyc + 1;
        rxd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (CPB) @(negedge clk);
            rxd = b[i];
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        rxd   = 1'b0;
        #1;
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%b data=%h fe=%b ov=%b busy=%b want all 0", rx_valid, rx_data, frame_err, overrun, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        k = cyc;
        while (cyc < k + 150) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_spurious @%0d: valid=%b fe=%b want 0 0", cyc - k, rx_valid, frame_err); end
        end
        k = cyc + 1;
        fork
            drive_frame(8'h5A, 1'b1);
            begin
                while (cyc < k + LAT) @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin errors++; $display("FAIL midrst_follow: valid=%b data=%h want 1 5a", rx_valid, rx_data); end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_overrun();
        test_coincident();
        test_random_frames();
        test_mid_reset();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
